// File: rtl/io_cycle_master.sv
// Z80-style I/O bus initiator: turns single-word requests into T1/T2/TW/T3 I/O cycles.
// Optional macro IO_TIMEOUT_EN adds a stuck-wait_n abort that completes the cycle with rsp_err=1.
module io_cycle_master #(
    parameter int AUTO_WAIT     = 1,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] addr,
    output logic [7:0] dout,
    input  logic [7:0] din,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       m1_n,
    input  logic       wait_n
);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

    localparam logic [2:0] AW = 3'(AUTO_WAIT);

    generate
        if (AUTO_WAIT < 0 || AUTO_WAIT > 7) begin : g_bad_auto_wait
            $error("AUTO_WAIT must be in 0..7");
        end
        if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
            $error("TIMEOUT_TICKS must be at least 1");
        end
    endgenerate

    state_t     state_reg;
    logic       wr_reg;
    logic [2:0] wait_cnt_reg;
    logic [2:0] wait_cnt_next;
    logic [7:0] addr_reg;
    logic [7:0] dout_reg;
    logic [7:0] rdata_reg;
    logic       iorq_n_reg;
    logic       rd_n_reg;
    logic       wr_n_reg;
    logic       valid_reg;
    logic       ready_reg;

    // Auto-wait count saturates so long device waits cannot wrap it.
    always_comb begin
        wait_cnt_next = (wait_cnt_reg < AW) ? wait_cnt_reg + 3'd1 : wait_cnt_reg;
    end

`ifdef IO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);

    logic [TO_W-1:0] to_cnt_reg;
    logic [TO_W-1:0] to_cnt_next;
    logic            err_reg;

    always_comb begin
        to_cnt_next = to_cnt_reg + 1'b1;
    end
    assign rsp_err = err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wr_reg       <= 1'b0;
            wait_cnt_reg <= 3'd0;
            addr_reg     <= 8'h00;
            dout_reg     <= 8'h00;
            rdata_reg    <= 8'h00;
            iorq_n_reg   <= 1'b1;
            rd_n_reg     <= 1'b1;
            wr_n_reg     <= 1'b1;
            valid_reg    <= 1'b0;
            ready_reg    <= 1'b1;
`ifdef IO_TIMEOUT_EN
            to_cnt_reg   <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Acceptance is the only transition that does not wait for ce.
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        dout_reg  <= req_wdata;
                        wr_reg    <= req_wr;
                        ready_reg <= 1'b0;
                        state_reg <= T1;
                    end
                end
                T1: begin
                    if (ce) begin
                        iorq_n_reg <= 1'b0;
                        rd_n_reg   <= wr_reg;
                        wr_n_reg   <= ~wr_reg;
                        state_reg  <= T2;
                    end
                end
                T2: begin
                    if (ce) begin
                        wait_cnt_reg <= 3'd0;
`ifdef IO_TIMEOUT_EN
                        to_cnt_reg   <= '0;
`endif
                        if (AUTO_WAIT > 0 || !wait_n) begin
                            state_reg <= TW;
                        end else begin
                            state_reg <= T3;
                        end
                    end
                end
                TW: begin
                    if (ce) begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_cnt_next >= AW && wait_n) begin
                            state_reg <= T3;
                        end
`ifdef IO_TIMEOUT_EN
                        // A device holding wait_n low too long is cut off here.
                        if (wait_n) begin
                            to_cnt_reg <= '0;
                        end else if (to_cnt_next == TO_LIMIT) begin
                            to_cnt_reg <= '0;
                            iorq_n_reg <= 1'b1;
                            rd_n_reg   <= 1'b1;
                            wr_n_reg   <= 1'b1;
                            valid_reg  <= 1'b1;
                            ready_reg  <= 1'b1;
                            err_reg    <= 1'b1;
                            if (!wr_reg) begin
                                rdata_reg <= 8'hFF;
                            end
                            state_reg  <= IDLE;
                        end else begin
                            to_cnt_reg <= to_cnt_next;
                        end
`endif
                    end
                end
                T3: begin
                    if (ce) begin
                        if (!wr_reg) begin
                            rdata_reg <= din;
                        end
                        iorq_n_reg <= 1'b1;
                        rd_n_reg   <= 1'b1;
                        wr_n_reg   <= 1'b1;
                        valid_reg  <= 1'b1;
                        ready_reg  <= 1'b1;
`ifdef IO_TIMEOUT_EN
                        err_reg    <= 1'b0;
`endif
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_reg;
    assign rsp_valid = valid_reg;
    assign rsp_rdata = rdata_reg;
    assign addr      = addr_reg;
    assign dout      = dout_reg;
    assign iorq_n    = iorq_n_reg;
    assign rd_n      = rd_n_reg;
    assign wr_n      = wr_n_reg;
    assign m1_n      = 1'b1;

endmodule
